// File: rtl/square_iterative.sv
// Reconstructs radicand = root*root + remainder with a shift-add multiplier
// that retires one root bit per clock, plus a flag for non-canonical remainders.
module square_iterative #(
    parameter int WIDTH_ROOT     = 8,
    parameter int WIDTH_RADICAND = 2*WIDTH_ROOT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [WIDTH_ROOT-1:0]     root,
    input  logic [WIDTH_ROOT:0]       remainder,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [WIDTH_RADICAND-1:0] radicand,
    output logic                      rem_err
);

    localparam int CNT_W = (WIDTH_ROOT > 1) ? $clog2(WIDTH_ROOT) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH_ROOT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                    state_q;
    logic [WIDTH_ROOT-1:0]     root_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [WIDTH_RADICAND-1:0] acc_q;
    logic [WIDTH_RADICAND-1:0] acc_d;
    logic [WIDTH_RADICAND-1:0] addend;
    logic                      rem_err_q;
    logic                      ready_in_q;
    logic                      valid_out_q;

    always_comb begin
        addend = '0;
        if (root_q[cnt_q]) begin
            addend = WIDTH_RADICAND'(root_q) << cnt_q;
        end
        acc_d = acc_q + addend;
    end

    // ready_in_q stays low for the first cycle out of reset, so no operand is taken then
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            root_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            rem_err_q   <= 1'b0;
            ready_in_q  <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ready_in_q && valid_in) begin
                        root_q     <= root;
                        acc_q      <= WIDTH_RADICAND'(remainder);
                        rem_err_q  <= (remainder > {root, 1'b0});
                        cnt_q      <= '0;
                        ready_in_q <= 1'b0;
                        state_q    <= BUSY;
                    end else begin
                        ready_in_q <= 1'b1;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        valid_out_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (ready_out) begin
                        valid_out_q <= 1'b0;
                        ready_in_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    valid_out_q <= 1'b0;
                    ready_in_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Result fields read as zero whenever no result is being offered
    assign ready_in  = ready_in_q;
    assign valid_out = valid_out_q;
    assign radicand  = valid_out_q ? acc_q : '0;
    assign rem_err   = valid_out_q & rem_err_q;

endmodule
